conv_output_drain_controller: RTL and testbench
===============================================

// Module: conv_output_drain_controller
// PURPOSE
//  Consumer end of the conv kernel controller's tile handshake. Latches each finished output tile on
//  nif_end (end of if accumulation), drains psums from the SA accumulators to the ofm buffer, then
//  pulses conv_compute to release the kernel controller's ifx_stall. Flags layer completion.
// PARAMETERS
//  sa_column_num     2    output rows (oy) per tile
//  row_num_in_sa     16   output channels per drain beat (one channel group)
//  pixels_in_row     32   ox pixels per tile; one beat carries one full pixel row
//  row_num_in_mode0  64   of per tile in mode 0
//  row_num_in_mode1  128  of per tile in mode 1
//  ofm_adr_width     16   ofm buffer word-address width
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-low reset
//  cfg_load        in   1   latch *_init (only sampled in IDLE)
//  mode_init       in   4   0/1 selects row_num_in_mode0/1
//  of_init         in   16  layer output channels
//  ox_init         in   16  layer output width
//  nif_end         in   1   tile accumulation complete (from conv_nif_add_end_delay)
//  layer_end       in   1   qualifies nif_end as last tile (com_control_end_delay)
//  ox_start,oy_start,of_start  in 16 1-based tile origin; pox,poy,pof in 16 valid tile extents
//  psum_rd_en      out  1   accumulator read strobe, read data valid next cycle
//  psum_rd_col     out  4   SA column (0..poy-1) being read
//  psum_rd_grp     out  4   channel group (0..ceil(pof/row_num_in_sa)-1)
//  ofm_wr_en       out  1   ofm write request; held until ofm_wr_ready
//  ofm_wr_ready    in   1   ofm buffer accepts write
//  ofm_wr_adr      out  ofm_adr_width  ofm word address
//  ofm_lane_mask   out  row_num_in_sa  valid channel lanes of beat
//  ofm_pix_mask    out  pixels_in_row  valid pixels of beat
//  conv_compute    out  1   one-cycle release pulse to kernel controller
//  busy            out  1   state != IDLE
//  layer_done      out  1   one-cycle pulse after the last tile's release
//  err_overrun     out  1   sticky: nif_end seen while busy
// BEHAVIOUR
//  - Reset (async assert, sync deassert): all outputs 0, state IDLE, cfg regs 0, counters 0. Mid-drain
//    reset aborts the tile, no conv_compute pulse.
//  - Cfg: in IDLE, cfg_load latches mode/of/ox. row_num = 64/128/0 for mode 0/1/other.
//    ngrp_total = ceil(of/16), xt = ceil(ox/pixels_in_row).
//  - FSM: IDLE -> RD -> WR -> (RD | REL) ; REL -> IDLE, or DONE if the layer flag is set; DONE -> IDLE.
//  - IDLE: nif_end latches tile fields and the layer_end flag, then -> RD next cycle.
//    Counters y=0, g=0. ng = ceil(pof/16).
//  - RD (1 cycle): psum_rd_en=1 with col=y and grp=g -> WR.
//  - WR: ofm_wr_en=1 until ofm_wr_ready. Outputs stay stable while stalled. On accept: g++.
//    When g wraps at ng-1, g=0 and y++. After (y=poy-1, g=ng-1) -> REL, else -> RD.
//    Minimum cost: 2 cycles per beat; total beats = poy*ng.
//  - ofm_wr_adr = ((oy_start-1+y)*ngrp_total + (of_start-1)/16 + g)*xt + (ox_start-1)/pixels_in_row.
//    Arithmetic is 32-bit internally, truncated to ofm_adr_width. Divides are shifts (power-of-2 params).
//  - ofm_lane_mask: all ones except the last group, which has low (pof-16*g) bits set.
//    ofm_pix_mask: low pox bits set.
//  - REL: conv_compute=1 for exactly 1 cycle.
//    DONE: layer_done=1 for 1 cycle, clear the layer flag.
//  - nif_end while busy: set err_overrun, ignore the tile. Cleared only by reset.
//    nif_end in the REL/DONE cycle also counts as an overrun.
//  - pof=0 or poy=0: RD/WR are skipped, go straight to REL (no writes).
// STRUCTURE
//  - Shared package conv_pkg: state enum (IDLE,RD,WR,REL,DONE), row_num_in_mode0/1 constants,
//    ceil-div-by-pow2 function.
//  - One sub-module: conv_drain_adr_gen (registered ofm_wr_adr and masks from tile fields, y, g),
//    updated on the RD cycle.
// TESTING
//  1. mode0, of=64, ox=32, tile (1,1,1) pox=32 poy=2 pof=64, ready=1 -> 8 writes at adr 0,1,2,3,4,5,6,7;
//     all masks full; conv_compute pulse 16 cycles after entering RD.
//  2. ox=40, second x tile ox_start=33 pox=8 -> ofm_pix_mask=32'h000000FF; xt=2, addresses odd.
//  3. of=40 pof=40 -> ng=3; beat g=2 lane_mask=16'h00FF; g=0,1 masks 16'hFFFF.
//  4. ofm_wr_ready low 5 cycles on beat 3 -> wr_en/adr/masks held constant; beat count still poy*ng.
//  5. nif_end with layer_end=1 -> conv_compute, then layer_done the next cycle; busy falls after DONE.
//  6. nif_end during WR -> err_overrun=1 sticky, beats unchanged. Reset low mid-drain -> all outputs 0
//     immediately, no release pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv output drain controller and its address generator.
package conv_pkg;

  localparam int sa_column_num    = 2;
  localparam int row_num_in_sa    = 16;
  localparam int pixels_in_row    = 32;
  localparam int row_num_in_mode0 = 64;
  localparam int row_num_in_mode1 = 128;
  localparam int ofm_adr_width    = 16;

  localparam int grp_shift = $clog2(row_num_in_sa);
  localparam int pix_shift = $clog2(pixels_in_row);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    REL,
    DONE
  } drain_state_t;

  function automatic logic [31:0] ceil_div_pow2(input logic [31:0] x, input int sh);
    return (x + ((32'd1 << sh) - 32'd1)) >> sh;
  endfunction

endpackage

// File: rtl/conv_output_drain_controller_if.sv
// Drain-side bus: accumulator read strobe toward the SA and write request toward the ofm buffer.
interface conv_output_drain_controller_if;
  import conv_pkg::*;

  logic                     psum_rd_en;
  logic [3:0]               psum_rd_col;
  logic [3:0]               psum_rd_grp;
  logic                     ofm_wr_en;
  logic                     ofm_wr_ready;
  logic [ofm_adr_width-1:0] ofm_wr_adr;
  logic [row_num_in_sa-1:0] ofm_lane_mask;
  logic [pixels_in_row-1:0] ofm_pix_mask;

  modport master (
    output psum_rd_en, psum_rd_col, psum_rd_grp,
    output ofm_wr_en, ofm_wr_adr, ofm_lane_mask, ofm_pix_mask,
    input  ofm_wr_ready
  );

  modport slave (
    input  psum_rd_en, psum_rd_col, psum_rd_grp,
    input  ofm_wr_en, ofm_wr_adr, ofm_lane_mask, ofm_pix_mask,
    output ofm_wr_ready
  );

endinterface

// File: rtl/conv_drain_adr_gen.sv
// Registered ofm word address and lane/pixel masks for the beat selected by (y, g).
module conv_drain_adr_gen
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [15:0]              ox_start,
  input  logic [15:0]              oy_start,
  input  logic [15:0]              of_start,
  input  logic [15:0]              pox,
  input  logic [15:0]              pof,
  input  logic [31:0]              ngrp_total,
  input  logic [31:0]              xt,
  input  logic [15:0]              y,
  input  logic [15:0]              g,
  output logic [ofm_adr_width-1:0] adr,
  output logic [row_num_in_sa-1:0] lane_mask,
  output logic [pixels_in_row-1:0] pix_mask
);

  logic [31:0]              row_idx;
  logic [31:0]              grp_idx;
  logic [31:0]              adr_full;
  logic [31:0]              lane_rem;
  logic [row_num_in_sa-1:0] lane_nxt;
  logic [pixels_in_row-1:0] pix_nxt;

  always_comb begin
    row_idx  = 32'(oy_start) - 32'd1 + 32'(y);
    grp_idx  = row_idx * ngrp_total + ((32'(of_start) - 32'd1) >> grp_shift) + 32'(g);
    adr_full = grp_idx * xt + ((32'(ox_start) - 32'd1) >> pix_shift);
    // only the last channel group can be short; earlier groups leave >= 16 lanes
    lane_rem = 32'(pof) - (32'(g) << grp_shift);
    lane_nxt = (lane_rem >= 32'(row_num_in_sa)) ? '1
             : row_num_in_sa'((32'd1 << lane_rem) - 32'd1);
    pix_nxt  = (32'(pox) >= 32'(pixels_in_row)) ? '1
             : pixels_in_row'((64'd1 << pox) - 64'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adr       <= '0;
      lane_mask <= '0;
      pix_mask  <= '0;
    end else if (load) begin
      adr       <= ofm_adr_width'(adr_full);
      lane_mask <= lane_nxt;
      pix_mask  <= pix_nxt;
    end
  end

endmodule

// File: rtl/conv_output_drain_controller.sv
// Drains one finished output tile from the SA accumulators into the ofm buffer, then releases the
// kernel controller with a conv_compute pulse.
//   state | meaning
//   IDLE  | waiting for nif_end; cfg_load accepted here
//   RD    | one-cycle accumulator read of column y, group g
//   WR    | ofm write request held until ofm_wr_ready
//   REL   | conv_compute release pulse
//   DONE  | layer_done pulse after the last tile
module conv_output_drain_controller
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [3:0]  mode_init,
  input  logic [15:0] of_init,
  input  logic [15:0] ox_init,
  input  logic        nif_end,
  input  logic        layer_end,
  input  logic [15:0] ox_start,
  input  logic [15:0] oy_start,
  input  logic [15:0] of_start,
  input  logic [15:0] pox,
  input  logic [15:0] poy,
  input  logic [15:0] pof,
  conv_output_drain_controller_if.master drain,
  output logic        conv_compute,
  output logic        busy,
  output logic        layer_done,
  output logic        err_overrun
);

  drain_state_t state, state_nxt;

  logic [3:0]  mode_r;
  logic [15:0] of_r, ox_r;
  logic [15:0] oxs_r, oys_r, ofs_r, pox_r, poy_r, pof_r, ng_r;
  logic [15:0] y, g;
  logic        layer_flag;
  logic        last_grp, last_beat;
  logic [31:0] ngrp_total, xt;
  logic [7:0]  row_num_unused;

  logic [ofm_adr_width-1:0] adr_q;
  logic [row_num_in_sa-1:0] lane_q;
  logic [pixels_in_row-1:0] pix_q;

  // rows per tile are fixed by the SA mode; the drain sequence itself never needs them
  assign row_num_unused = (mode_r == 4'd0) ? 8'(row_num_in_mode0)
                        : (mode_r == 4'd1) ? 8'(row_num_in_mode1) : 8'd0;

  assign ngrp_total = ceil_div_pow2(32'(of_r), grp_shift);
  assign xt         = ceil_div_pow2(32'(ox_r), pix_shift);
  assign last_grp   = (g == ng_r - 16'd1);
  assign last_beat  = last_grp && (y == poy_r - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (nif_end) state_nxt = (pof == 16'd0 || poy == 16'd0) ? REL : RD;
      RD:      state_nxt = WR;
      WR:      if (drain.ofm_wr_ready) state_nxt = last_beat ? REL : RD;
      REL:     state_nxt = layer_flag ? DONE : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    drain.psum_rd_en    = (state == RD);
    drain.psum_rd_col   = y[3:0];
    drain.psum_rd_grp   = g[3:0];
    drain.ofm_wr_en     = (state == WR);
    drain.ofm_wr_adr    = adr_q;
    drain.ofm_lane_mask = lane_q;
    drain.ofm_pix_mask  = pix_q;
    conv_compute        = (state == REL);
    layer_done          = (state == DONE);
    busy                = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r      <= '0;
      of_r        <= '0;
      ox_r        <= '0;
      oxs_r       <= '0;
      oys_r       <= '0;
      ofs_r       <= '0;
      pox_r       <= '0;
      poy_r       <= '0;
      pof_r       <= '0;
      ng_r        <= '0;
      y           <= '0;
      g           <= '0;
      layer_flag  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (state == IDLE && cfg_load) begin
        mode_r <= mode_init;
        of_r   <= of_init;
        ox_r   <= ox_init;
      end
      if (nif_end && state != IDLE) err_overrun <= 1'b1;
      unique case (state)
        IDLE: if (nif_end) begin
          oxs_r      <= ox_start;
          oys_r      <= oy_start;
          ofs_r      <= of_start;
          pox_r      <= pox;
          poy_r      <= poy;
          pof_r      <= pof;
          ng_r       <= 16'(ceil_div_pow2(32'(pof), grp_shift));
          layer_flag <= layer_end;
          y          <= '0;
          g          <= '0;
        end
        WR: if (drain.ofm_wr_ready) begin
          if (last_grp) begin
            g <= '0;
            y <= y + 16'd1;
          end else begin
            g <= g + 16'd1;
          end
        end
        DONE:    layer_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  conv_drain_adr_gen u_adr_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (state == RD),
    .ox_start   (oxs_r),
    .oy_start   (oys_r),
    .of_start   (ofs_r),
    .pox        (pox_r),
    .pof        (pof_r),
    .ngrp_total (ngrp_total),
    .xt         (xt),
    .y          (y),
    .g          (g),
    .adr        (adr_q),
    .lane_mask  (lane_q),
    .pix_mask   (pix_q)
  );

endmodule

// File: tb/tb_conv_output_drain_controller.sv
// Directed and randomized tile drains checked against an arithmetic model of the beat sequence.
module tb_conv_output_drain_controller;

  typedef struct {
    int oxs;
    int oys;
    int ofs;
    int pox;
    int poy;
    int pof;
  } tile_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [3:0]  mode_init;
  logic [15:0] of_init, ox_init;
  logic        nif_end, layer_end;
  logic [15:0] ox_start, oy_start, of_start, pox, poy, pof;
  logic        conv_compute, busy, layer_done, err_overrun;

  int tests  = 0;
  int failed = 0;
  int cur_of = 0;
  int cur_ox = 0;

  conv_output_drain_controller_if dif ();

  conv_output_drain_controller dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_load     (cfg_load),
    .mode_init    (mode_init),
    .of_init      (of_init),
    .ox_init      (ox_init),
    .nif_end      (nif_end),
    .layer_end    (layer_end),
    .ox_start     (ox_start),
    .oy_start     (oy_start),
    .of_start     (of_start),
    .pox          (pox),
    .poy          (poy),
    .pof          (pof),
    .drain        (dif),
    .conv_compute (conv_compute),
    .busy         (busy),
    .layer_done   (layer_done),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_adr(tile_t t, int k);
    int ng, yy, gg, ngt, xtl;
    ng  = (t.pof + 15) / 16;
    yy  = k / ng;
    gg  = k % ng;
    ngt = (cur_of + 15) / 16;
    xtl = (cur_ox + 31) / 32;
    return (((t.oys - 1 + yy) * ngt + (t.ofs - 1) / 16 + gg) * xtl + (t.oxs - 1) / 32) & 32'hFFFF;
  endfunction

  function automatic logic [63:0] low_ones(int n, int width);
    if (n >= width) return (64'd1 << width) - 64'd1;
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic drive_tile(input tile_t t);
    ox_start = 16'(t.oxs);
    oy_start = 16'(t.oys);
    of_start = 16'(t.ofs);
    pox      = 16'(t.pox);
    poy      = 16'(t.poy);
    pof      = 16'(t.pof);
  endtask

  task automatic do_cfg(input int mode, input int ofv, input int oxv);
    mode_init = 4'(mode);
    of_init   = 16'(ofv);
    ox_init   = 16'(oxv);
    cfg_load  = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    cur_of    = ofv;
    cur_ox    = oxv;
  endtask

  task automatic run_tile(input tile_t t, input bit lend, input int stall_beat,
                          input int stall_len, input bit inject);
    int ng, total, beats, reads, cyc, stall_cnt, rel_cyc, exp_lat;
    bit injected;
    ng        = (t.pof + 15) / 16;
    total     = (t.pof == 0 || t.poy == 0) ? 0 : t.poy * ng;
    beats     = 0;
    reads     = 0;
    cyc       = 0;
    stall_cnt = 0;
    rel_cyc   = -1;
    injected  = 1'b0;
    drive_tile(t);
    nif_end   = 1'b1;
    layer_end = lend;
    @(posedge clk); #1;
    nif_end   = 1'b0;
    layer_end = 1'b0;
    while (rel_cyc < 0 && cyc < 4000) begin
      if (nif_end) begin
        nif_end   = 1'b0;
        layer_end = 1'b0;
        drive_tile(t);
      end
      if (dif.psum_rd_en) begin
        chk("rd_col", 64'(dif.psum_rd_col), 64'((reads / (ng == 0 ? 1 : ng)) & 15));
        chk("rd_grp", 64'(dif.psum_rd_grp), 64'((reads % (ng == 0 ? 1 : ng)) & 15));
        reads++;
      end
      if (conv_compute) begin
        rel_cyc = cyc;
      end else if (dif.ofm_wr_en) begin
        if (inject && !injected && beats == 1) begin
          injected  = 1'b1;
          nif_end   = 1'b1;
          layer_end = 1'b1;
          ox_start  = ox_start + 16'd32;
        end
        if (beats < total) begin
          chk("wr_adr", 64'(dif.ofm_wr_adr), 64'(exp_adr(t, beats)));
          chk("lane_mask", 64'(dif.ofm_lane_mask), low_ones(t.pof - 16 * (beats % ng), 16));
          chk("pix_mask", 64'(dif.ofm_pix_mask), low_ones(t.pox, 32));
        end else begin
          chk("extra_beat", 64'(beats), 64'(total - 1));
        end
        if (beats == stall_beat && stall_cnt < stall_len) begin
          dif.ofm_wr_ready = 1'b0;
          stall_cnt++;
        end else begin
          dif.ofm_wr_ready = 1'b1;
          beats++;
        end
      end
      if (rel_cyc < 0) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    dif.ofm_wr_ready = 1'b1;
    exp_lat = 2 * total + ((stall_beat < total) ? stall_len : 0);
    chk("rel_seen", 64'(rel_cyc >= 0), 64'd1);
    chk("beats", 64'(beats), 64'(total));
    chk("reads", 64'(reads), 64'(total));
    chk("rel_latency", 64'(rel_cyc), 64'(exp_lat));
    chk("busy_rel", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("rel_one_cycle", 64'(conv_compute), 64'd0);
    chk("layer_done", 64'(layer_done), 64'(lend));
    if (lend) begin
      chk("busy_done", 64'(busy), 64'd1);
      @(posedge clk); #1;
      chk("layer_done_pulse", 64'(layer_done), 64'd0);
    end
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    tile_t t;
    int    rel_cnt;
    reset            = 1'b0;
    cfg_load         = 1'b0;
    mode_init        = '0;
    of_init          = '0;
    ox_init          = '0;
    nif_end          = 1'b0;
    layer_end        = 1'b0;
    dif.ofm_wr_ready = 1'b1;
    t = '{oxs: 1, oys: 1, ofs: 1, pox: 32, poy: 2, pof: 64};
    drive_tile(t);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_conv_compute", 64'(conv_compute), 64'd0);
    chk("rst_layer_done", 64'(layer_done), 64'd0);
    chk("rst_err", 64'(err_overrun), 64'd0);
    chk("rst_rd_en", 64'(dif.psum_rd_en), 64'd0);
    chk("rst_wr_en", 64'(dif.ofm_wr_en), 64'd0);
    chk("rst_adr", 64'(dif.ofm_wr_adr), 64'd0);
    chk("rst_masks", {dif.ofm_lane_mask, dif.ofm_pix_mask}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // full tile, addresses 0..7
    do_cfg(0, 64, 32);
    run_tile(t, 1'b0, 99, 0, 1'b0);
    // second x tile of a 40-wide layer
    do_cfg(0, 64, 40);
    t = '{oxs: 33, oys: 1, ofs: 1, pox: 8, poy: 2, pof: 64};
    run_tile(t, 1'b0, 99, 0, 1'b0);
    // partial last channel group
    do_cfg(1, 40, 32);
    t = '{oxs: 1, oys: 1, ofs: 1, pox: 32, poy: 2, pof: 40};
    run_tile(t, 1'b0, 99, 0, 1'b0);
    // ready stall on beat 3
    do_cfg(0, 64, 32);
    t = '{oxs: 1, oys: 1, ofs: 1, pox: 32, poy: 2, pof: 64};
    run_tile(t, 1'b0, 3, 5, 1'b0);
    // last tile of the layer
    run_tile(t, 1'b1, 99, 0, 1'b0);
    // empty tiles go straight to release
    t = '{oxs: 1, oys: 3, ofs: 17, pox: 32, poy: 2, pof: 0};
    run_tile(t, 1'b0, 99, 0, 1'b0);
    t = '{oxs: 1, oys: 3, ofs: 17, pox: 32, poy: 0, pof: 16};
    run_tile(t, 1'b1, 99, 0, 1'b0);
    chk("err_clear", 64'(err_overrun), 64'd0);
    // overrun during WR is flagged and ignored
    t = '{oxs: 1, oys: 2, ofs: 1, pox: 20, poy: 2, pof: 48};
    run_tile(t, 1'b0, 99, 0, 1'b1);
    chk("err_set", 64'(err_overrun), 64'd1);

    for (int i = 0; i < 20; i++) begin
      do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(1, 300)), int'($urandom_range(1, 200)));
      t.oxs = int'($urandom_range(1, 200));
      t.oys = int'($urandom_range(1, 40));
      t.ofs = int'($urandom_range(1, 300));
      t.pox = int'($urandom_range(0, 40));
      t.poy = int'($urandom_range(0, 3));
      t.pof = int'($urandom_range(0, 40));
      run_tile(t, 1'(($urandom & 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0);
    end
    chk("err_sticky", 64'(err_overrun), 64'd1);

    // reset in the middle of a drain
    t = '{oxs: 1, oys: 1, ofs: 1, pox: 32, poy: 2, pof: 64};
    drive_tile(t);
    nif_end = 1'b1;
    @(posedge clk); #1;
    nif_end = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err_overrun), 64'd0);
    chk("mid_rst_strobes", {dif.psum_rd_en, dif.ofm_wr_en, conv_compute, layer_done}, 64'd0);
    chk("mid_rst_adr", 64'(dif.ofm_wr_adr), 64'd0);
    chk("mid_rst_masks", {dif.ofm_lane_mask, dif.ofm_pix_mask}, 64'd0);
    chk("mid_rst_rd_sel", {dif.psum_rd_col, dif.psum_rd_grp}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    rel_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (conv_compute) rel_cnt++;
    end
    chk("no_release_after_rst", 64'(rel_cnt), 64'd0);
    chk("idle_after_rst", 64'(busy), 64'd0);
    // cfg registers were cleared, so every address collapses to 0
    cur_of = 0;
    cur_ox = 0;
    run_tile(t, 1'b0, 99, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
